// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, state codes and
// datapath mux select values (ordering matches the datapath mux inputs).
package multicycle_ctrl_fsm_pkg;

  localparam int OPW  = 6;
  localparam int SELW = 2;
  localparam int ALUW = 2;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_J     = 6'h02;
  localparam logic [OPW-1:0] OP_JAL   = 6'h03;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;
  localparam logic [OPW-1:0] OP_HALT  = 6'h3F;
  localparam logic [OPW-1:0] FN_JR    = 6'h08;

  localparam logic [SELW-1:0] REGDST_RT = 2'd0;
  localparam logic [SELW-1:0] REGDST_RD = 2'd1;
  localparam logic [SELW-1:0] REGDST_RA = 2'd2;

  localparam logic [SELW-1:0] WB_ALU = 2'd0;
  localparam logic [SELW-1:0] WB_MEM = 2'd1;
  localparam logic [SELW-1:0] WB_PC4 = 2'd2;

  localparam logic [SELW-1:0] PCSEL_PC4 = 2'd0;
  localparam logic [SELW-1:0] PCSEL_BR  = 2'd1;
  localparam logic [SELW-1:0] PCSEL_JMP = 2'd2;
  localparam logic [SELW-1:0] PCSEL_RS  = 2'd3;

  localparam logic [ALUW-1:0] ALUOP_ADD   = 2'd0;
  localparam logic [ALUW-1:0] ALUOP_SUB   = 2'd1;
  localparam logic [ALUW-1:0] ALUOP_FUNCT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic rtype;
    logic jr;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic halt;
  } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the FSM (slave side) and the IR/ALU/memory datapath (master side).
interface multicycle_ctrl_fsm_if;
  import multicycle_ctrl_fsm_pkg::*;

  logic            run;
  logic [OPW-1:0]  opcode;
  logic [OPW-1:0]  funct;
  logic            alu_zero;
  logic            mem_ready;
  logic            mem_re;
  logic            mem_we;
  logic            ir_we;
  logic            pc_we;
  logic [SELW-1:0] pc_sel;
  logic            reg_we;
  logic [SELW-1:0] reg_dst_sel;
  logic [SELW-1:0] wb_sel;
  logic            alu_src_sel;
  logic [ALUW-1:0] alu_op;
  logic            halted;
  logic            illegal;

  modport slave (
    input  run, opcode, funct, alu_zero, mem_ready,
    output mem_re, mem_we, ir_we, pc_we, pc_sel, reg_we, reg_dst_sel,
           wb_sel, alu_src_sel, alu_op, halted, illegal
  );

  modport master (
    output run, opcode, funct, alu_zero, mem_ready,
    input  mem_re, mem_we, ir_we, pc_we, pc_sel, reg_we, reg_dst_sel,
           wb_sel, alu_src_sel, alu_op, halted, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_instr_class_decode.sv
// Combinational opcode/funct classifier: one-hot instruction class plus illegal flag.
module instr_class_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  output instr_class_t   cls,
  output logic           illegal
);

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      // Every funct under opcode 0 is accepted as an ALU op except jr.
      OP_RTYPE: begin
        if (funct == FN_JR) cls.jr = 1'b1;
        else                cls.rtype = 1'b1;
      end
      OP_ADDI: cls.addi = 1'b1;
      OP_LW:   cls.lw   = 1'b1;
      OP_SW:   cls.sw   = 1'b1;
      OP_BEQ:  cls.beq  = 1'b1;
      OP_J:    cls.j    = 1'b1;
      OP_JAL:  cls.jal  = 1'b1;
      OP_HALT: cls.halt = 1'b1;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving all datapath selects and strobes.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_fsm_if.slave bus
);

  state_t          state_reg, state_next;
  logic            illegal_reg, illegal_next;
  instr_class_t    cls;
  logic            cls_illegal;

  logic            mem_re, mem_we, ir_we, pc_we, reg_we, alu_src_sel, halted;
  logic [SELW-1:0] pc_sel, reg_dst_sel, wb_sel;
  logic [ALUW-1:0] alu_op;

  instr_class_decode u_decode (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .cls     (cls),
    .illegal (cls_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PCSEL_PC4;
    reg_we       = 1'b0;
    reg_dst_sel  = REGDST_RT;
    wb_sel       = WB_ALU;
    alu_src_sel  = 1'b0;
    alu_op       = ALUOP_ADD;
    halted       = 1'b0;

    case (state_reg)
      S_IDLE: if (bus.run) state_next = S_FETCH;
      S_FETCH: begin
        mem_re = 1'b1;
        if (bus.mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          pc_sel     = PCSEL_PC4;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls_illegal) begin
          illegal_next = 1'b1;
          state_next   = S_HALT;
        end else if (cls.halt) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = S_FETCH;
        if (cls.rtype) begin
          alu_op     = ALUOP_FUNCT;
          state_next = S_WB;
        end else if (cls.jr) begin
          pc_we  = 1'b1;
          pc_sel = PCSEL_RS;
        end else if (cls.addi) begin
          alu_src_sel = 1'b1;
          state_next  = S_WB;
        end else if (cls.lw || cls.sw) begin
          alu_src_sel = 1'b1;
          state_next  = S_MEM;
        end else if (cls.beq) begin
          alu_op = ALUOP_SUB;
          pc_sel = PCSEL_BR;
          pc_we  = bus.alu_zero;
        end else if (cls.j) begin
          pc_we  = 1'b1;
          pc_sel = PCSEL_JMP;
        end else if (cls.jal) begin
          // PC already holds PC+4 from FETCH, so the link write happens alongside the jump.
          pc_we       = 1'b1;
          pc_sel      = PCSEL_JMP;
          reg_we      = 1'b1;
          reg_dst_sel = REGDST_RA;
          wb_sel      = WB_PC4;
        end
      end
      S_MEM: begin
        alu_src_sel = 1'b1;
        mem_re      = cls.lw;
        mem_we      = cls.sw;
        if (bus.mem_ready) state_next = cls.lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_we     = 1'b1;
        state_next = S_FETCH;
        if (cls.lw) begin
          reg_dst_sel = REGDST_RT;
          wb_sel      = WB_MEM;
        end else if (cls.rtype) begin
          reg_dst_sel = REGDST_RD;
          wb_sel      = WB_ALU;
        end else begin
          reg_dst_sel = REGDST_RT;
          wb_sel      = WB_ALU;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_IDLE;
    endcase

    // Nothing may strobe while reset is held, whatever state we were in.
    if (rst) begin
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = PCSEL_PC4;
      reg_we      = 1'b0;
      reg_dst_sel = REGDST_RT;
      wb_sel      = WB_ALU;
      alu_src_sel = 1'b0;
      alu_op      = ALUOP_ADD;
      halted      = 1'b0;
    end
  end

  assign bus.mem_re      = mem_re;
  assign bus.mem_we      = mem_we;
  assign bus.ir_we       = ir_we;
  assign bus.pc_we       = pc_we;
  assign bus.pc_sel      = pc_sel;
  assign bus.reg_we      = reg_we;
  assign bus.reg_dst_sel = reg_dst_sel;
  assign bus.wb_sel      = wb_sel;
  assign bus.alu_src_sel = alu_src_sel;
  assign bus.alu_op      = alu_op;
  assign bus.halted      = halted;
  assign bus.illegal     = illegal_reg & ~rst;

endmodule
